// File: rtl/mux_arb2_pkg.sv
// Shared types and constants for the mux_arb2 two-requester arbiter.
package mux_arb2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } state_e;

   localparam int BEAT_CNT_W    = 8;
   localparam int STATS_W       = 16;
   localparam int MAX_BURST_DEF = 4;

   function automatic logic [1:0] idx2onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-input round-robin picker: on a tie the requester that
// was not granted last wins.
module rr_pick2
   import mux_arb2_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio_last,
   output logic [1:0] pick,
   output logic       pick_idx
);

   always_comb begin
      pick     = 2'b00;
      pick_idx = 1'b0;
      case (req)
         2'b01: begin
            pick     = 2'b01;
            pick_idx = 1'b0;
         end
         2'b10: begin
            pick     = 2'b10;
            pick_idx = 1'b1;
         end
         2'b11: begin
            pick     = idx2onehot(~prio_last);
            pick_idx = ~prio_last;
         end
         default: begin
            pick     = 2'b00;
            pick_idx = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mux_arb2.sv
// Round-robin 2:1 arbiter/sequencer with burst cap driving one valid/ready channel.
// Optional per-requester beat counters when MUX_ARB2_STATS_EN is defined.
module mux_arb2
   import mux_arb2_pkg::*;
#(
   parameter int DATA_W    = 1,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        last,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   input  logic              dout_ready,
   output logic [1:0]        gnt,
   output logic              sel,
   output logic              dout_valid,
   output logic [DATA_W-1:0] dout
`ifdef MUX_ARB2_STATS_EN
   ,
   output logic [STATS_W-1:0] beats0,
   output logic [STATS_W-1:0] beats1
`endif
);

   localparam logic [BEAT_CNT_W-1:0] MAX_BURST_C = BEAT_CNT_W'(MAX_BURST);

   state_e                  state_q, state_d;
   logic                    sel_q, sel_d;
   logic                    prio_last_q, prio_last_d;
   logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

   logic                    granted;
   logic                    cur;
   logic                    beat;
   logic [BEAT_CNT_W-1:0]   cnt_inc;
   logic                    last_hit;
   logic                    drop_hit;
   logic                    cap_hit;
   logic                    rel;
   logic                    regrant_ok;
   logic [1:0]              pick_req;
   logic [1:0]              pick;
   logic                    pick_idx;

   // The state encoding is the one-hot grant itself, so gnt is a plain register.
   assign gnt        = state_q;
   assign sel        = sel_q;
   assign granted    = (state_q != IDLE);
   assign cur        = (state_q == G1);
   assign dout_valid = gnt[sel_q] & req[sel_q];
   assign beat       = dout_valid & dout_ready;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_sel
         assign dout[gi] = sel_q ? din1[gi] : din0[gi];
      end
   endgenerate

   assign cnt_inc    = beat_cnt_q + 1'b1;
   assign last_hit   = beat & last[cur];
   assign drop_hit   = ~req[cur];
   assign cap_hit    = beat & (cnt_inc == MAX_BURST_C);
   assign rel        = granted & (last_hit | drop_hit | cap_hit);
   assign regrant_ok = cap_hit & ~last_hit & req[cur];

   // While granted, the current owner only stays eligible for a cap-only re-grant.
   assign pick_req = granted ? (req & ~(regrant_ok ? 2'b00 : idx2onehot(cur))) : req;

   rr_pick2 u_pick (
      .req       (pick_req),
      .prio_last (prio_last_q),
      .pick      (pick),
      .pick_idx  (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      prio_last_d = prio_last_q;
      beat_cnt_d  = beat_cnt_q;
      if (!granted || rel) begin
         if (pick != 2'b00) begin
            state_d     = pick_idx ? G1 : G0;
            sel_d       = pick_idx;
            prio_last_d = pick_idx;
            beat_cnt_d  = '0;
         end else begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end
      end else if (beat) begin
         beat_cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         prio_last_q <= 1'b1;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         prio_last_q <= prio_last_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

`ifdef MUX_ARB2_STATS_EN
   logic [STATS_W-1:0] beats0_q, beats1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         beats0_q <= '0;
         beats1_q <= '0;
      end else begin
         if (beat && !sel_q && (beats0_q != {STATS_W{1'b1}}))
            beats0_q <= beats0_q + 1'b1;
         if (beat && sel_q && (beats1_q != {STATS_W{1'b1}}))
            beats1_q <= beats1_q + 1'b1;
      end
   end

   assign beats0 = beats0_q;
   assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_mux_arb2.sv
// Self-checking bench for mux_arb2: directed scenarios pinned by literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_mux_arb2;

   localparam int DW   = 4;
   localparam int MAXB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req;
   logic [1:0]    last;
   logic [DW-1:0] din0;
   logic [DW-1:0] din1;
   logic          dout_ready;
   logic [1:0]    gnt;
   logic          sel;
   logic          dout_valid;
   logic [DW-1:0] dout;
`ifdef MUX_ARB2_STATS_EN
   logic [15:0]   beats0;
   logic [15:0]   beats1;
`endif

   int errors = 0;
   int checks = 0;

   // behavioural model state: owner -1 means nobody holds the path
   int m_owner, m_sel, m_prio, m_cnt, m_b0, m_b1;

   mux_arb2 #(.DATA_W(DW), .MAX_BURST(MAXB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .last       (last),
      .din0       (din0),
      .din1       (din1),
      .dout_ready (dout_ready),
      .gnt        (gnt),
      .sel        (sel),
      .dout_valid (dout_valid),
      .dout       (dout)
`ifdef MUX_ARB2_STATS_EN
      ,
      .beats0     (beats0),
      .beats1     (beats1)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_sel = 0; m_prio = 1; m_cnt = 0; m_b0 = 0; m_b1 = 0;
   endtask

   task automatic model_grant(input int who);
      m_owner = who; m_sel = who; m_prio = who; m_cnt = 0;
   endtask

   // Advance the model across one rising edge using the inputs currently applied.
   task automatic model_step();
      bit beat, lh, drop, cap;
      int i, o, cnt_new;
      if (rst) begin
         model_reset();
         return;
      end
      beat = (m_owner >= 0) && req[m_owner] && dout_ready;
      if (beat && m_owner == 0 && m_b0 < 65535) m_b0++;
      if (beat && m_owner == 1 && m_b1 < 65535) m_b1++;
      if (m_owner < 0) begin
         if (req == 2'b11)      model_grant(1 - m_prio);
         else if (req == 2'b01) model_grant(0);
         else if (req == 2'b10) model_grant(1);
      end else begin
         i = m_owner;
         o = 1 - i;
         cnt_new = m_cnt + (beat ? 1 : 0);
         lh   = beat && last[i];
         drop = !req[i];
         cap  = beat && (cnt_new == MAXB);
         if (lh || drop || cap) begin
            if (req[o])                    model_grant(o);
            else if (cap && !lh && req[i]) model_grant(i);
            else begin
               m_owner = -1;
               m_cnt   = 0;
            end
         end else begin
            m_cnt = cnt_new;
         end
      end
   endtask

   task automatic compare_all();
      logic [1:0]    e_gnt;
      logic          e_dv;
      logic [DW-1:0] e_dout;
      e_gnt  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
      e_dv   = (m_owner >= 0) && req[m_owner];
      e_dout = (m_sel != 0) ? din1 : din0;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("dout_valid", 32'(dout_valid), 32'(e_dv));
      chk("dout", 32'(dout), 32'(e_dout));
`ifdef MUX_ARB2_STATS_EN
      chk("beats0", 32'(beats0), 32'(m_b0));
      chk("beats1", 32'(beats1), 32'(m_b1));
`endif
   endtask

   // Called just after a falling edge: apply inputs, compare, cross one rising edge.
   task automatic step(input logic r, input logic [1:0] q, input logic [1:0] l, input logic rdy);
      rst        = r;
      req        = q;
      last       = l;
      dout_ready = rdy;
      #1;
      compare_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   initial begin
      bit [1:0] want;
      rst = 1'b1; req = 2'b00; last = 2'b00; dout_ready = 1'b0;
      din0 = 4'h5; din1 = 4'hC;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);

      step(1'b1, 2'b00, 2'b00, 1'b1);
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_sel", 32'(sel), 32'h0);
      chk("reset_dv", 32'(dout_valid), 32'h0);

      // tie from idle after reset: requester 0 first, then zero-bubble handoff
      step(1'b0, 2'b11, 2'b00, 1'b1);
      chk("tie_first_gnt", 32'(gnt), 32'h1);
      step(1'b0, 2'b11, 2'b01, 1'b1);
      chk("handoff_gnt", 32'(gnt), 32'h2);
      chk("handoff_sel", 32'(sel), 32'h1);
      step(1'b0, 2'b10, 2'b10, 1'b1);
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_sel_hold", 32'(sel), 32'h1);

      // single requester, last on the third beat
      din0 = 4'hA;
      step(1'b0, 2'b01, 2'b00, 1'b1);
      chk("single_gnt", 32'(gnt), 32'h1);
      chk("single_dout", 32'(dout), 32'hA);
      step(1'b0, 2'b01, 2'b00, 1'b1);
      step(1'b0, 2'b01, 2'b00, 1'b1);
      chk("single_mid_gnt", 32'(gnt), 32'h1);
      step(1'b0, 2'b01, 2'b01, 1'b1);
      chk("single_end_gnt", 32'(gnt), 32'h0);

      // backpressure on requester 1
      step(1'b0, 2'b10, 2'b00, 1'b0);
      chk("bp_gnt", 32'(gnt), 32'h2);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 2'b10, 2'b00, 1'b0);
         chk("bp_hold_gnt", 32'(gnt), 32'h2);
         chk("bp_hold_sel", 32'(sel), 32'h1);
      end
      step(1'b0, 2'b10, 2'b00, 1'b1);
      chk("bp_beat1_gnt", 32'(gnt), 32'h2);
      step(1'b0, 2'b10, 2'b10, 1'b1);
      chk("bp_release_gnt", 32'(gnt), 32'h0);

      // burst cap: both saturated, strict alternation every MAXB beats
      step(1'b0, 2'b11, 2'b00, 1'b1);
      for (int k = 1; k <= 4 * MAXB; k++) begin
         chk("cap_gnt", 32'(gnt), (((k - 1) / MAXB) % 2 == 0) ? 32'h1 : 32'h2);
         step(1'b0, 2'b11, 2'b00, 1'b1);
      end

      // reset mid-burst at beat 2
      step(1'b0, 2'b01, 2'b00, 1'b1);
      step(1'b0, 2'b01, 2'b00, 1'b1);
      step(1'b1, 2'b01, 2'b00, 1'b1);
      chk("rst_mid_gnt", 32'(gnt), 32'h0);
      chk("rst_mid_sel", 32'(sel), 32'h0);
      step(1'b0, 2'b11, 2'b00, 1'b1);
      for (int k = 0; k < MAXB; k++) begin
         chk("post_rst_burst_gnt", 32'(gnt), 32'h1);
         step(1'b0, 2'b11, 2'b00, 1'b1);
      end
      chk("post_rst_rotate_gnt", 32'(gnt), 32'h2);

      // randomized traffic
      want = 2'b00;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 2; b++)
            if ($urandom_range(0, 9) == 0) want[b] = ~want[b];
         din0 = DW'($urandom);
         din1 = DW'($urandom);
         step(($urandom_range(0, 199) == 0),
              want,
              {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
              ($urandom_range(0, 9) < 7));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_arb2.md
# mux_arb2

Two-requester round-robin arbiter and sequencer for a shared 2:1 data-select path. It owns the select line and steers one requester's data onto a single downstream valid/ready channel. Each grant is held for a burst, bounded by a beat cap. It sits between two producer blocks and one consumer, in front of the lab's shared output path.

## Interface
Parameters:
- DATA_W, 1, width of each data input and of dout
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..255)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  request per requester; must stay high until its last beat transfers
- last  in  2  per-requester end-of-burst marker, qualified by a transfer beat
- din0  in  DATA_W  requester 0 data
- din1  in  DATA_W  requester 1 data
- dout_ready  in  1  consumer ready
- gnt  out  2  registered one-hot grant (00 when idle)
- sel  out  1  registered select; 0 = din0, 1 = din1
- dout_valid  out  1  gnt[sel] & req[sel]
- dout  out  DATA_W  sel ? din1 : din0, combinational from registered sel

## Operation
- FSM states: IDLE, G0, G1. gnt = 01 in G0, 10 in G1, 00 in IDLE.
- sel holds its last value in IDLE: 0 after reset, otherwise the last granted requester.
- Beat: a cycle with dout_valid & dout_ready.
- beat_cnt (8 bit) increments per beat and clears on every grant change or re-grant.
- Release of grant i happens on any of:
  - a beat with last[i]=1
  - req[i] dropping
  - a beat that makes beat_cnt reach MAX_BURST
- Next state after release:
  - other requester's req high: grant the other (direct handoff, no idle cycle)
  - otherwise req[i] still high (cap release only): re-grant i, beat_cnt cleared
  - otherwise: IDLE
- From IDLE:
  - single req: grant it
  - both req high: grant the requester that is not prio_last
- prio_last (1 bit) records the last granted requester. It is updated on every entry to G0/G1 and resets to 1, so requester 0 wins the first tie.
- req edges on the non-granted side have no effect until release.
- Simultaneous release condition and other req rising in the same cycle: the other requester is granted next cycle.

## Timing
- Reset values: gnt=00, sel=0, dout_valid=0, beat_cnt=0, prio_last=1, state IDLE.
- rst overrides everything, including mid-burst. A beat presented in the rst cycle is not counted and the grant is dropped.
- Request to grant latency: 1 cycle. A req seen at edge N gives gnt at edge N+1. The first beat is possible in cycle N+1.
- Handoff: the last beat of grant i at edge N gives gnt of j and sel=j at edge N+1. Zero bubble.
- dout and dout_valid are combinational from registered sel/gnt and the inputs. There is no registered data stage.
- Back-to-back bursts with both requesters saturated: strict alternation every MAX_BURST beats.

## Configuration
- MUX_ARB2_STATS_EN defined:
  - adds outputs beats0, beats1 (16 bit each), counting beats per requester
  - both counters saturate at 16'hFFFF and clear on rst
- Not defined: the ports and counters are absent; no other behaviour change.

## Structure
- Package mux_arb2_pkg holds:
  - state enum (IDLE, G0, G1)
  - BEAT_CNT_W = 8
  - STATS_W = 16
  - default MAX_BURST
- One sub-module, rr_pick2: combinational two-input round-robin picker.
  - Inputs: req[1:0], prio_last.
  - Outputs: one-hot pick and pick index.
  - The FSM uses it for both the IDLE and handoff decisions.
- The data select is a per-bit 2:1 select, generated over DATA_W.

## Test plan
- Reset mid-burst: G0 active at beat 2, rst pulsed -> next cycle gnt=00, sel=0, dout_valid=0, beat_cnt=0.
- Single requester: req=01, last on 3rd beat, dout_ready=1 -> gnt=01 one cycle after req; three beats of din0; then IDLE with gnt=00.
- Tie from IDLE after reset: req=11 -> gnt=01 first. After its last beat, gnt=10 on the next cycle with no idle cycle.
- Burst cap: MAX_BURST=4, req=11, last never asserted, dout_ready=1 -> gnt alternates 01/10 every 4 beats for at least 3 rotations.
- Backpressure: G1 granted, dout_ready=0 for 5 cycles -> gnt, sel and beat_cnt hold. Then 2 beats with last on the 2nd -> release.
- Stats (MUX_ARB2_STATS_EN): 10 beats from requester 0 and 7 from requester 1 -> beats0=10, beats1=7. A forced count at 16'hFFFF stays saturated.
